frag_pkt_sender: RTL

- Fragmentation stage directly downstream of the send controller.
- On a rising edge of start_frag_pkt it latches the encapsulated packet from the encap stage and splits it into NUMBER_FRAG fixed-width fragments, sent LSB-first.
- Fragments go out on a valid/ready link toward the lane arbiter.
- After the last fragment is accepted it returns a one-cycle frag_pkt_done pulse.
- A replay is simply a new rising edge of start_frag_pkt, which re-latches and resends.

---
 rtl/frag_pkt_sender_if.sv | 32 +++
 rtl/frag_pkt_sender.sv | 123 ++++++++++++
 2 files changed

// File: rtl/frag_pkt_sender_if.sv
// Fragment link from the fragmentation stage toward the lane arbiter.
// The sender drives the fragment and its sideband. The arbiter drives frag_ready.
interface frag_pkt_sender_if #(
    parameter int FRAG_WIDTH = 32,
    parameter int IDX_WIDTH  = 3,
    parameter int DFX_WIDTH  = 2
);
    logic                  frag_valid;
    logic                  frag_ready;
    logic [FRAG_WIDTH-1:0] frag_data;
    logic [IDX_WIDTH-1:0]  frag_idx;
    logic                  frag_last;
    logic [DFX_WIDTH-1:0]  frag_dst_dfx;

    modport master (
        output frag_valid,
        output frag_data,
        output frag_idx,
        output frag_last,
        output frag_dst_dfx,
        input  frag_ready
    );

    modport slave (
        input  frag_valid,
        input  frag_data,
        input  frag_idx,
        input  frag_last,
        input  frag_dst_dfx,
        output frag_ready
    );
endinterface

// File: rtl/frag_pkt_sender.sv
// Fragmentation stage. A rising edge of start_frag_pkt latches the encapsulated
// packet. The packet is then sent as NUMBER_FRAG fragments, LSB fragment first,
// over a valid/ready link. After the last fragment is accepted, the module
// emits a one-cycle frag_pkt_done pulse. A replay is just another rising edge.
module frag_pkt_sender #(
    parameter int FRAG_WIDTH  = 32,
    parameter int NUMBER_FRAG = 5,
    parameter int IDX_WIDTH   = 3,
    parameter int DFX_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_frag_pkt,
    input  logic [NUMBER_FRAG*FRAG_WIDTH-1:0] pkt_data,
    input  logic [DFX_WIDTH-1:0]              pkt_dst_dfx,
    frag_pkt_sender_if.master                 m_frag,
    output logic                              frag_pkt_done,
    output logic                              busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUMBER_FRAG - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                          r_state;
    logic                            r_start_prev;
    logic [NUMBER_FRAG*FRAG_WIDTH-1:0] r_buf;
    logic [IDX_WIDTH-1:0]            r_idx;
    logic                            r_frag_valid;
    logic [FRAG_WIDTH-1:0]           r_frag_data;
    logic                            r_frag_last;
    logic [DFX_WIDTH-1:0]            r_frag_dst_dfx;
    logic                            r_done;
    logic                            r_busy;

    logic                            w_start_edge;
    logic                            w_accept;
    logic [IDX_WIDTH-1:0]            w_idx_nxt;
    logic [NUMBER_FRAG*FRAG_WIDTH-1:0] w_buf_shift;
    logic [FRAG_WIDTH-1:0]           w_data_nxt;

    // Start edge detect, handshake, and the next fragment to present after an accept
    always_comb begin
        w_start_edge = start_frag_pkt & ~r_start_prev;
        w_accept     = r_frag_valid & m_frag.frag_ready;
        w_idx_nxt    = r_idx + 1'b1;
        w_buf_shift  = r_buf >> (32'(w_idx_nxt) * FRAG_WIDTH);
        w_data_nxt   = w_buf_shift[FRAG_WIDTH-1:0];
    end

    // Control FSM. All link outputs are registered, so each transition loads
    // the values belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_start_prev   <= 1'b0;
            r_buf          <= '0;
            r_idx          <= '0;
            r_frag_valid   <= 1'b0;
            r_frag_data    <= '0;
            r_frag_last    <= 1'b0;
            r_frag_dst_dfx <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_start_prev <= start_frag_pkt;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state        <= SEND;
                        r_buf          <= pkt_data;
                        r_idx          <= '0;
                        r_frag_valid   <= 1'b1;
                        r_frag_data    <= pkt_data[FRAG_WIDTH-1:0];
                        r_frag_last    <= (LAST_IDX == '0);
                        r_frag_dst_dfx <= pkt_dst_dfx;
                        r_busy         <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (r_frag_last) begin
                            r_state      <= DONE;
                            r_idx        <= '0;
                            r_frag_valid <= 1'b0;
                            r_frag_data  <= '0;
                            r_frag_last  <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_idx       <= w_idx_nxt;
                            r_frag_data <= w_data_nxt;
                            r_frag_last <= (w_idx_nxt == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Drive the link and status from registers
    always_comb begin
        m_frag.frag_valid   = r_frag_valid;
        m_frag.frag_data    = r_frag_data;
        m_frag.frag_idx     = r_frag_valid ? r_idx : '0;
        m_frag.frag_last    = r_frag_last;
        m_frag.frag_dst_dfx = r_frag_dst_dfx;
        frag_pkt_done       = r_done;
        busy                = r_busy;
    end

endmodule
